// File: rtl/id_pkg.sv
// id_pkg: shared widths, types and channel names for the ID operand unit
package id_pkg;
    localparam int NREG = 32;
    localparam int AW   = 5;
    localparam int DW   = 32;
    localparam int LATW = 4;
    typedef logic [AW-1:0]   reg_addr_t;
    typedef logic [DW-1:0]   word_t;
    typedef logic [LATW-1:0] lat_t;
    localparam reg_addr_t R0 = '0;
    typedef enum logic [1:0] {CH_EX, CH_MEM, CH_WB} fwd_chan_e;
endpackage

// File: rtl/id_fwd_mux.sv
// id_fwd_mux: priority bypass select and RAW hazard flag for one read port
module id_fwd_mux
    import id_pkg::*;
#(
    parameter int NFWD  = 3,
    parameter int BR_EX = 0
) (
    input  logic               en_i,
    input  logic [AW-1:0]      addr_i,
    input  logic [DW-1:0]      rf_rdata_i,
    input  logic               cnt_busy_i,
    input  logic               branch_use_i,
    input  logic [NFWD-1:0]    fwd_we_i,
    input  logic [NFWD-1:0]    fwd_ready_i,
    input  logic [NFWD*AW-1:0] fwd_waddr_i,
    input  logic [NFWD*DW-1:0] fwd_wdata_i,
    output logic [DW-1:0]      rdata_o,
    output logic               hazard_o
);
    logic  hit, hit_ready, hit_ex;
    word_t hit_data;
    // scan oldest to youngest so the youngest matching channel overwrites
    always_comb begin
        hit       = 1'b0;
        hit_ready = 1'b0;
        hit_ex    = 1'b0;
        hit_data  = '0;
        for (int c = NFWD - 1; c >= 0; c--) begin
            if (fwd_we_i[c] && fwd_waddr_i[c*AW +: AW] == addr_i) begin
                hit       = 1'b1;
                hit_ready = fwd_ready_i[c];
                hit_ex    = (c == int'(CH_EX));
                hit_data  = fwd_wdata_i[c*DW +: DW];
            end
        end
    end
    logic raw;
    assign raw      = (addr_i != R0) && (hit ? (!hit_ready || (hit_ex && branch_use_i && BR_EX == 0)) : cnt_busy_i);
    assign hazard_o = en_i & raw;
    assign rdata_o  = (addr_i == R0) ? '0 : hit ? hit_data : rf_rdata_i;
endmodule

// File: rtl/id_operand_scoreboard.sv
// id_operand_scoreboard: ID operand bypass, long-latency scoreboard and stall generation
module id_operand_scoreboard
    import id_pkg::*;
#(
    parameter int NRP   = 2,
    parameter int NFWD  = 3,
    parameter int BR_EX = 0
) (
    input  logic               clk_i,
    input  logic               rst_i,
    input  logic               flush_i,
    input  logic               id_stall_i,
    input  logic               issue_valid_i,
    input  logic               issue_wreg_i,
    input  logic [AW-1:0]      issue_waddr_i,
    input  logic [LATW-1:0]    issue_lat_i,
    input  logic               branch_use_i,
    input  logic [NRP-1:0]     rd_en_i,
    input  logic [NRP*AW-1:0]  rd_addr_i,
    input  logic [NRP*DW-1:0]  rf_rdata_i,
    input  logic [NFWD-1:0]    fwd_we_i,
    input  logic [NFWD-1:0]    fwd_ready_i,
    input  logic [NFWD*AW-1:0] fwd_waddr_i,
    input  logic [NFWD*DW-1:0] fwd_wdata_i,
    output logic [NRP*DW-1:0]  rdata_o,
    output logic               stall_o,
    output logic               busy_o,
    output logic [31:0]        stall_cnt_o
);
    lat_t         cnt_q [NREG];
    lat_t         cnt_d [NREG];
    logic         busy_d;
    logic [31:0]  stall_cnt_q;
    logic [NRP-1:0] raw;
    for (genvar p = 0; p < NRP; p++) begin : g_port
        id_fwd_mux #(.NFWD(NFWD), .BR_EX(BR_EX)) u_mux (
            .en_i        (rd_en_i[p]),
            .addr_i      (rd_addr_i[p*AW +: AW]),
            .rf_rdata_i  (rf_rdata_i[p*DW +: DW]),
            .cnt_busy_i  (cnt_q[rd_addr_i[p*AW +: AW]] != '0),
            .branch_use_i(branch_use_i),
            .fwd_we_i    (fwd_we_i),
            .fwd_ready_i (fwd_ready_i),
            .fwd_waddr_i (fwd_waddr_i),
            .fwd_wdata_i (fwd_wdata_i),
            .rdata_o     (rdata_o[p*DW +: DW]),
            .hazard_o    (raw[p])
        );
    end
    logic waw, fire, load;
    assign waw     = issue_wreg_i && issue_waddr_i != R0 && cnt_q[issue_waddr_i] > issue_lat_i;
    assign stall_o = issue_valid_i & ~flush_i & (|raw | waw);
    assign fire    = issue_valid_i & ~id_stall_i & ~stall_o & ~flush_i;
    assign load    = fire & issue_wreg_i & (issue_waddr_i != R0);
    // flush clears, an accepted writer loads its latency, everything else counts down
    always_comb begin
        busy_d = 1'b0;
        for (int r = 0; r < NREG; r++) begin
            cnt_d[r] = flush_i ? '0
                     : (load && issue_waddr_i == reg_addr_t'(r)) ? issue_lat_i
                     : (cnt_q[r] != '0) ? cnt_q[r] - 1'b1 : '0;
            busy_d   = busy_d | (cnt_d[r] != '0);
        end
    end
    // scoreboard, busy flag and saturating stall counter
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            for (int r = 0; r < NREG; r++) cnt_q[r] <= '0;
            busy_o      <= 1'b0;
            stall_cnt_q <= '0;
        end else begin
            for (int r = 0; r < NREG; r++) cnt_q[r] <= cnt_d[r];
            busy_o <= busy_d;
            if (stall_o && stall_cnt_q != '1) stall_cnt_q <= stall_cnt_q + 32'd1;
        end
    end
    assign stall_cnt_o = stall_cnt_q;
endmodule

// File: tb/tb_id_operand_scoreboard.sv
// tb_id_operand_scoreboard: directed checks of bypass, scoreboard, flush and stall counting
module tb_id_operand_scoreboard;
    logic        clk = 0;
    logic        rst, flush, id_stall, issue_valid, issue_wreg, branch_use;
    logic [4:0]  issue_waddr;
    logic [3:0]  issue_lat;
    logic [1:0]  rd_en;
    logic [9:0]  rd_addr;
    logic [63:0] rf_rdata;
    logic [2:0]  fwd_we, fwd_ready;
    logic [14:0] fwd_waddr;
    logic [95:0] fwd_wdata;
    logic [63:0] rdata0, rdata1;
    logic        stall0, stall1, busy0, busy1;
    logic [31:0] scnt0, scnt1;
    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    id_operand_scoreboard #(.BR_EX(0)) dut0 (
        .clk_i(clk), .rst_i(rst), .flush_i(flush), .id_stall_i(id_stall),
        .issue_valid_i(issue_valid), .issue_wreg_i(issue_wreg), .issue_waddr_i(issue_waddr),
        .issue_lat_i(issue_lat), .branch_use_i(branch_use), .rd_en_i(rd_en), .rd_addr_i(rd_addr),
        .rf_rdata_i(rf_rdata), .fwd_we_i(fwd_we), .fwd_ready_i(fwd_ready), .fwd_waddr_i(fwd_waddr),
        .fwd_wdata_i(fwd_wdata), .rdata_o(rdata0), .stall_o(stall0), .busy_o(busy0), .stall_cnt_o(scnt0));

    id_operand_scoreboard #(.BR_EX(1)) dut1 (
        .clk_i(clk), .rst_i(rst), .flush_i(flush), .id_stall_i(id_stall),
        .issue_valid_i(issue_valid), .issue_wreg_i(issue_wreg), .issue_waddr_i(issue_waddr),
        .issue_lat_i(issue_lat), .branch_use_i(branch_use), .rd_en_i(rd_en), .rd_addr_i(rd_addr),
        .rf_rdata_i(rf_rdata), .fwd_we_i(fwd_we), .fwd_ready_i(fwd_ready), .fwd_waddr_i(fwd_waddr),
        .fwd_wdata_i(fwd_wdata), .rdata_o(rdata1), .stall_o(stall1), .busy_o(busy1), .stall_cnt_o(scnt1));

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic clear();
        flush = 0; id_stall = 0; issue_valid = 0; issue_wreg = 0; issue_waddr = 0; issue_lat = 0;
        branch_use = 0; rd_en = 0; rd_addr = 0; rf_rdata = 0;
        fwd_we = 0; fwd_ready = 0; fwd_waddr = 0; fwd_wdata = 0;
    endtask

    task automatic set_rd(input int p, input logic en, input logic [4:0] a, input logic [31:0] d);
        rd_en[p] = en; rd_addr[p*5 +: 5] = a; rf_rdata[p*32 +: 32] = d;
    endtask

    task automatic set_fwd(input int c, input logic we, input logic rdy, input logic [4:0] a, input logic [31:0] d);
        fwd_we[c] = we; fwd_ready[c] = rdy; fwd_waddr[c*5 +: 5] = a; fwd_wdata[c*32 +: 32] = d;
    endtask

    task automatic do_reset();
        clear();
        rst = 1;
        cyc(); cyc();
        rst = 0;
        #1;
    endtask

    task automatic issue(input logic [4:0] a, input logic [3:0] l);
        issue_valid = 1; issue_wreg = 1; issue_waddr = a; issue_lat = l;
    endtask

    task automatic test_reset();
        do_reset();
        checks++; if (busy0 !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b want 0", busy0); end
        checks++; if (scnt0 !== 32'd0) begin errors++; $display("FAIL reset_scnt: got %0d want 0", scnt0); end
        checks++; if (stall0 !== 1'b0) begin errors++; $display("FAIL reset_stall: got %b want 0", stall0); end
        issue(5'd20, 4'd7);
        cyc();
        clear();
        checks++; if (busy0 !== 1'b1) begin errors++; $display("FAIL midrst_busy_pre: got %b want 1", busy0); end
        rst = 1;
        cyc();
        rst = 0;
        issue_valid = 1; set_rd(0, 1, 5'd20, 32'h1234);
        #1;
        checks++; if (busy0 !== 1'b0) begin errors++; $display("FAIL midrst_busy: got %b want 0", busy0); end
        checks++; if (stall0 !== 1'b0) begin errors++; $display("FAIL midrst_stall: got %b want 0", stall0); end
        checks++; if (rdata0[31:0] !== 32'h1234) begin errors++; $display("FAIL midrst_rdata: got %h want 00001234", rdata0[31:0]); end
    endtask

    task automatic test_priority();
        do_reset();
        issue_valid = 1;
        set_fwd(0, 1, 1, 5'd5, 32'hAAAA);
        set_fwd(2, 1, 1, 5'd5, 32'hBBBB);
        set_rd(0, 1, 5'd5, 32'hCCCC);
        set_rd(1, 1, 5'd3, 32'h3333);
        #1;
        checks++; if (rdata0[31:0] !== 32'hAAAA) begin errors++; $display("FAIL prio_p0: got %h want 0000aaaa", rdata0[31:0]); end
        checks++; if (rdata0[63:32] !== 32'h3333) begin errors++; $display("FAIL prio_p1_rf: got %h want 00003333", rdata0[63:32]); end
        checks++; if (stall0 !== 1'b0) begin errors++; $display("FAIL prio_stall: got %b want 0", stall0); end
        set_fwd(0, 0, 1, 5'd5, 32'hAAAA);
        #1;
        checks++; if (rdata0[31:0] !== 32'hBBBB) begin errors++; $display("FAIL prio_wb: got %h want 0000bbbb", rdata0[31:0]); end
    endtask

    task automatic test_load_use();
        do_reset();
        issue_valid = 1;
        set_fwd(0, 1, 0, 5'd7, 32'h0);
        set_fwd(2, 1, 1, 5'd7, 32'hDEAD);
        set_rd(0, 1, 5'd7, 32'h1111);
        #1;
        checks++; if (stall0 !== 1'b1) begin errors++; $display("FAIL loaduse_stall: got %b want 1", stall0); end
        rd_en[0] = 0;
        #1;
        checks++; if (stall0 !== 1'b0) begin errors++; $display("FAIL loaduse_masked: got %b want 0", stall0); end
        rd_en[0] = 1;
        cyc();
        set_fwd(0, 0, 0, 5'd0, 32'h0);
        set_fwd(1, 1, 1, 5'd7, 32'h7777);
        #1;
        checks++; if (stall0 !== 1'b0) begin errors++; $display("FAIL loaduse_clear: got %b want 0", stall0); end
        checks++; if (rdata0[31:0] !== 32'h7777) begin errors++; $display("FAIL loaduse_data: got %h want 00007777", rdata0[31:0]); end
    endtask

    task automatic test_latency();
        logic [3:0] exp_st;
        do_reset();
        issue(5'd9, 4'd3);
        cyc();
        issue_wreg = 0; set_rd(1, 1, 5'd9, 32'h9999);
        exp_st = 4'b0111;
        for (int t = 1; t <= 4; t++) begin
            #1;
            checks++; if (stall0 !== exp_st[t-1]) begin errors++; $display("FAIL lat_stall_t%0d: got %b want %b", t, stall0, exp_st[t-1]); end
            checks++; if (busy0 !== exp_st[t-1]) begin errors++; $display("FAIL lat_busy_t%0d: got %b want %b", t, busy0, exp_st[t-1]); end
            cyc();
        end
    endtask

    task automatic test_waw();
        logic [3:0] exp_st;
        do_reset();
        issue(5'd4, 4'd5);
        cyc();
        issue(5'd4, 4'd2);
        set_rd(1, 1, 5'd0, 32'h5555);
        set_fwd(0, 1, 1, 5'd0, 32'hDEAD);
        exp_st = 4'b0111;
        for (int t = 1; t <= 4; t++) begin
            #1;
            checks++; if (stall0 !== exp_st[t-1]) begin errors++; $display("FAIL waw_stall_t%0d: got %b want %b", t, stall0, exp_st[t-1]); end
            cyc();
        end
        checks++; if (rdata0[63:32] !== 32'h0) begin errors++; $display("FAIL r0_data: got %h want 00000000", rdata0[63:32]); end
        clear();
        issue_valid = 1; set_rd(0, 1, 5'd4, 32'h0);
        #1;
        checks++; if (stall0 !== 1'b1) begin errors++; $display("FAIL waw_reload: got %b want 1", stall0); end
    endtask

    task automatic test_flush();
        do_reset();
        issue(5'd10, 4'd5);
        cyc();
        flush = 1; issue(5'd11, 4'd6);
        set_rd(0, 1, 5'd10, 32'h0);
        #1;
        checks++; if (stall0 !== 1'b0) begin errors++; $display("FAIL flush_stall: got %b want 0", stall0); end
        cyc();
        flush = 0; issue_wreg = 0;
        set_rd(1, 1, 5'd11, 32'h0);
        #1;
        checks++; if (busy0 !== 1'b0) begin errors++; $display("FAIL flush_busy: got %b want 0", busy0); end
        checks++; if (stall0 !== 1'b0) begin errors++; $display("FAIL flush_after: got %b want 0", stall0); end
    endtask

    task automatic test_id_stall();
        do_reset();
        id_stall = 1; issue(5'd12, 4'd3);
        cyc();
        clear();
        #1;
        checks++; if (busy0 !== 1'b0) begin errors++; $display("FAIL idstall_noload: got %b want 0", busy0); end
        issue(5'd13, 4'd2);
        cyc();
        clear();
        id_stall = 1; issue_valid = 1; set_rd(0, 1, 5'd13, 32'h0);
        cyc(); cyc();
        #1;
        checks++; if (stall0 !== 1'b0) begin errors++; $display("FAIL idstall_decrement: got %b want 0", stall0); end
    endtask

    task automatic test_branch();
        do_reset();
        issue_valid = 1; branch_use = 1;
        set_fwd(0, 1, 1, 5'd6, 32'h6666);
        set_rd(0, 1, 5'd6, 32'h0);
        #1;
        checks++; if (stall0 !== 1'b1) begin errors++; $display("FAIL br_ex0_stall: got %b want 1", stall0); end
        checks++; if (stall1 !== 1'b0) begin errors++; $display("FAIL br_ex1_stall: got %b want 0", stall1); end
        checks++; if (rdata1[31:0] !== 32'h6666) begin errors++; $display("FAIL br_ex1_data: got %h want 00006666", rdata1[31:0]); end
        cyc(); cyc(); cyc();
        branch_use = 0;
        #1;
        checks++; if (scnt0 !== 32'd3) begin errors++; $display("FAIL br_scnt0: got %0d want 3", scnt0); end
        checks++; if (scnt1 !== 32'd0) begin errors++; $display("FAIL br_scnt1: got %0d want 0", scnt1); end
        checks++; if (stall0 !== 1'b0) begin errors++; $display("FAIL br_nobranch: got %b want 0", stall0); end
        checks++; if (rdata0[31:0] !== 32'h6666) begin errors++; $display("FAIL br_nobranch_data: got %h want 00006666", rdata0[31:0]); end
        cyc();
        checks++; if (scnt0 !== 32'd3) begin errors++; $display("FAIL br_scnt0_hold: got %0d want 3", scnt0); end
    endtask

    initial begin
        test_reset();
        test_priority();
        test_load_use();
        test_latency();
        test_waw();
        test_flush();
        test_id_stall();
        test_branch();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
